// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the fetch controller slice.
package fetch_pkg;

    localparam int DEF_D  = 12;
    localparam int DEF_W  = 9;
    localparam int DEF_CW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection: sequential increment, absolute branch or PC-relative branch.
module fetch_next_pc
    import fetch_pkg::*;
#(
    parameter int D = DEF_D
) (
    input  logic [D-1:0] i_address,
    input  logic [D-1:0] i_instr_pc,
    input  logic         i_branch_en,
    input  logic         i_branch_rel,
    input  logic [D-1:0] i_branch_target,
    output logic [D-1:0] o_next_pc
);

    // Relative offsets are taken from the branching instruction's own address,
    // and all additions wrap modulo 2^D.
    always_comb begin
        o_next_pc = i_address + D'(1);
        if (i_branch_en) begin
            if (i_branch_rel) begin
                o_next_pc = i_instr_pc + i_branch_target;
            end else begin
                o_next_pc = i_branch_target;
            end
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Program-counter sequencer: drives the ROM address, registers the fetched word, and runs start/halt.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int             D          = DEF_D,
    parameter int             W          = DEF_W,
    parameter logic [D-1:0]   START_ADDR = '0,
    parameter int             CW         = DEF_CW
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_start,
    input  logic          i_stall,
    input  logic          i_branch_en,
    input  logic          i_branch_rel,
    input  logic [D-1:0]  i_branch_target,
    input  logic          i_halt,
    input  logic [W-1:0]  i_machine_code,
    output logic [D-1:0]  o_address,
    output logic [W-1:0]  o_instr,
    output logic [D-1:0]  o_instr_pc,
    output logic          o_instr_valid,
    output logic          o_busy,
    output logic          o_done,
    output logic [CW-1:0] o_cycle_count
);

    fetch_state_t  r_state;
    logic [D-1:0]  r_address;
    logic [W-1:0]  r_instr;
    logic [D-1:0]  r_instr_pc;
    logic          r_instr_valid;
    logic          r_busy;
    logic          r_done;
    logic [CW-1:0] r_cycle_count;

    logic          w_take_branch;
    logic [D-1:0]  w_next_pc;

    // Branches are only honoured against a live instruction in the IR.
    assign w_take_branch = i_branch_en & r_instr_valid;

    fetch_next_pc #(
        .D(D)
    ) u_next_pc (
        .i_address       (r_address),
        .i_instr_pc      (r_instr_pc),
        .i_branch_en     (w_take_branch),
        .i_branch_rel    (i_branch_rel),
        .i_branch_target (i_branch_target),
        .o_next_pc       (w_next_pc)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state       <= IDLE;
            r_address     <= START_ADDR;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_cycle_count <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (i_start) begin
                        r_state       <= RUN;
                        r_address     <= START_ADDR;
                        r_instr_valid <= 1'b0;
                        r_busy        <= 1'b1;
                        r_done        <= 1'b0;
                        r_cycle_count <= '0;
                    end
                end
                RUN: begin
                    if (!i_stall) begin
                        if (r_cycle_count != '1) begin
                            r_cycle_count <= r_cycle_count + CW'(1);
                        end
                        if (i_halt && r_instr_valid) begin
                            r_state       <= DONE;
                            r_instr_valid <= 1'b0;
                            r_busy        <= 1'b0;
                            r_done        <= 1'b1;
                        end else begin
                            // A taken branch still loads the IR but marks the word as a bubble.
                            r_instr       <= i_machine_code;
                            r_instr_pc    <= r_address;
                            r_instr_valid <= !w_take_branch;
                            r_address     <= w_next_pc;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_address     = r_address;
    assign o_instr       = r_instr;
    assign o_instr_pc    = r_instr_pc;
    assign o_instr_valid = r_instr_valid;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_cycle_count = r_cycle_count;

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural fetch model.
module tb_fetch_controller;

    localparam int           D        = 12;
    localparam int           W        = 9;
    localparam int           CW       = 6;
    localparam logic [D-1:0] START    = 12'd0;
    localparam int           MAXCOUNT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          resetN = 1'b0;
    logic          start = 1'b0;
    logic          stall = 1'b0;
    logic          branchEn = 1'b0;
    logic          branchRel = 1'b0;
    logic [D-1:0]  branchTarget = '0;
    logic          halt = 1'b0;
    logic [W-1:0]  machineCode;
    logic [D-1:0]  address;
    logic [W-1:0]  instr;
    logic [D-1:0]  instrPc;
    logic          instrValid;
    logic          busy;
    logic          done;
    logic [CW-1:0] cycleCount;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the sequencer's architectural state.
    logic          mRunning;
    logic          mFinished;
    logic [D-1:0]  mPc;
    logic [W-1:0]  mIr;
    logic [D-1:0]  mIrPc;
    logic          mValid;
    int            mCount;

    logic [D-1:0]  savedPc;

    always #5 clk = ~clk;

    // Identity ROM: each word holds the low bits of its own address.
    function automatic logic [W-1:0] romWord(input logic [D-1:0] a);
        return a[W-1:0];
    endfunction

    assign machineCode = romWord(address);

    fetch_controller #(
        .D(D), .W(W), .START_ADDR(START), .CW(CW)
    ) dut (
        .i_clk           (clk),
        .i_reset_n       (resetN),
        .i_start         (start),
        .i_stall         (stall),
        .i_branch_en     (branchEn),
        .i_branch_rel    (branchRel),
        .i_branch_target (branchTarget),
        .i_halt          (halt),
        .i_machine_code  (machineCode),
        .o_address       (address),
        .o_instr         (instr),
        .o_instr_pc      (instrPc),
        .o_instr_valid   (instrValid),
        .o_busy          (busy),
        .o_done          (done),
        .o_cycle_count   (cycleCount)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic stepModel(input logic rn, input logic st, input logic sl, input logic be,
                             input logic br, input logic [D-1:0] bt, input logic hl);
        logic [D-1:0] target;
        if (!rn) begin
            mRunning = 1'b0; mFinished = 1'b0; mPc = START;
            mIr = '0; mIrPc = '0; mValid = 1'b0; mCount = 0;
        end else if (!mRunning) begin
            if (st) begin
                mRunning = 1'b1; mFinished = 1'b0; mPc = START;
                mValid = 1'b0; mCount = 0;
            end
        end else if (!sl) begin
            if (mCount < MAXCOUNT) mCount++;
            if (hl && mValid) begin
                mRunning = 1'b0; mFinished = 1'b1; mValid = 1'b0;
            end else begin
                target = br ? (mIrPc + bt) : bt;
                mIr = romWord(mPc);
                mIrPc = mPc;
                if (be && mValid) begin
                    mPc = target;
                    mValid = 1'b0;
                end else begin
                    mPc = mPc + 12'd1;
                    mValid = 1'b1;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic rn, input logic st, input logic sl, input logic be,
                                 input logic br, input logic [D-1:0] bt, input logic hl);
        resetN = rn; start = st; stall = sl; branchEn = be;
        branchRel = br; branchTarget = bt; halt = hl;
        @(posedge clk);
        stepModel(rn, st, sl, be, br, bt, hl);
        #1;
        checkOutput("address",    32'(address),    32'(mPc));
        checkOutput("instr",      32'(instr),      32'(mIr));
        checkOutput("instrPc",    32'(instrPc),    32'(mIrPc));
        checkOutput("instrValid", 32'(instrValid), 32'(mValid));
        checkOutput("busy",       32'(busy),       32'(mRunning));
        checkOutput("done",       32'(done),       32'(mFinished));
        checkOutput("cycleCount", 32'(cycleCount), 32'(mCount));
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic runUntilPc(input logic [D-1:0] target, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (mValid && mIrPc == target) break;
            idleCycle();
        end
        checkOutput("reachPc", 32'(instrPc), 32'(target));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "Addr"},  32'(address),    32'(START));
        checkOutput({tag, "Instr"}, 32'(instr),      32'd0);
        checkOutput({tag, "IrPc"},  32'(instrPc),    32'd0);
        checkOutput({tag, "Valid"}, 32'(instrValid), 32'd0);
        checkOutput({tag, "Busy"},  32'(busy),       32'd0);
        checkOutput({tag, "Done"},  32'(done),       32'd0);
        checkOutput({tag, "Count"}, 32'(cycleCount), 32'd0);
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        checkResetState("rst");

        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("startBusy", 32'(busy), 32'd1);
        idleCycle();
        checkOutput("firstPc", 32'(instrPc), 32'd0);
        checkOutput("firstValid", 32'(instrValid), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            idleCycle();
            checkOutput("seqPc", 32'(instrPc), 32'(i));
        end

        // Absolute branch at instr_pc 3 to 20.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'd20, 1'b0);
        checkOutput("absBubble", 32'(instrValid), 32'd0);
        checkOutput("absAddr", 32'(address), 32'd20);
        idleCycle();
        checkOutput("absPc", 32'(instrPc), 32'd20);

        // Back to 4, then stall three cycles at instr_pc 5.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'd4, 1'b0);
        runUntilPc(12'd5, 6);
        savedPc = mPc;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'd99, 1'b1);
            checkOutput("stallPc", 32'(instrPc), 32'd5);
            checkOutput("stallAddr", 32'(address), 32'(savedPc));
        end
        idleCycle();
        checkOutput("postStallPc", 32'(instrPc), 32'd6);

        // Relative branch backwards by 2 from instr_pc 10.
        runUntilPc(12'd10, 8);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'hFFE, 1'b0);
        checkOutput("relBubble", 32'(instrValid), 32'd0);
        idleCycle();
        checkOutput("relBackPc", 32'(instrPc), 32'd8);

        // Relative branch that wraps past the top of the address space.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'd4094, 1'b0);
        runUntilPc(12'd4094, 4);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'd3, 1'b0);
        idleCycle();
        checkOutput("relWrapPc", 32'(instrPc), 32'd1);

        // Sequential increment wrap from 4095 to 0.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'd4095, 1'b0);
        runUntilPc(12'd4095, 4);
        idleCycle();
        checkOutput("incWrapPc", 32'(instrPc), 32'd0);

        // Halt together with a branch: halt wins, address holds.
        savedPc = mPc;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'd77, 1'b1);
        checkOutput("haltDone", 32'(done), 32'd1);
        checkOutput("haltBusy", 32'(busy), 32'd0);
        checkOutput("haltAddr", 32'(address), 32'(savedPc));
        idleCycle();
        checkOutput("doneLevel", 32'(done), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("restartDone", 32'(done), 32'd0);
        checkOutput("restartCount", 32'(cycleCount), 32'd0);

        // Reset in the middle of a run.
        runUntilPc(12'd7, 12);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        checkResetState("midRst");
        for (int i = 0; i < 3; i++) begin
            idleCycle();
            checkOutput("stayIdleBusy", 32'(busy), 32'd0);
            checkOutput("stayIdleAddr", 32'(address), 32'(START));
        end

        // Random traffic, including ignored start/branch/halt and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(($urandom_range(0, 63) != 0),
                          ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 5) == 0),
                          1'($urandom_range(0, 1)),
                          12'($urandom),
                          ($urandom_range(0, 39) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
